serial_adder_ctrl: RTL

//  Bit-serial N-bit adder front end. Captures two WIDTH-bit operands plus carry-in,

---
 rtl/serial_adder_ctrl_if.sv | 36 +++
 rtl/serial_adder_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   // Both channels use valid/ready: a transfer happens on a rising clk edge
   // where valid and ready are both high; valid must not depend on ready.
   modport master (
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, one bit per clock, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the subtract mode (A - B via ~B and carry-in 1).
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic ci_i,
   output logic s_o,
   output logic co_o
);
   assign s_o  = a_i ^ b_i ^ ci_i;
   assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   serial_adder_ctrl_if.slave    bus_io,
   output logic                  busy_o,
   output logic [1:0]            state_o
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             fa_s, fa_co;

   full_adder u_fa (
      .a_i  (a_sr_q[0]),
      .b_i  (b_sr_q[0]),
      .ci_i (carry_q),
      .s_o  (fa_s),
      .co_o (fa_co)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus_io.in_valid) begin
               a_sr_d  = bus_io.a;
`ifdef SERIAL_ADDER_SUB_EN
               b_sr_d  = bus_io.sub ? ~bus_io.b : bus_io.b;
               carry_d = bus_io.sub | bus_io.cin;
`else
               b_sr_d  = bus_io.b;
               carry_d = bus_io.cin;
`endif
               cnt_d   = '0;
               sum_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
            sum_d   = {fa_s, sum_q[WIDTH-1:1]};
            carry_d = fa_co;
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            if (cnt_q == CW'(WIDTH - 1)) begin
               cout_d  = fa_co;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus_io.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus_io.in_ready  = (state_q == S_IDLE);
   assign bus_io.out_valid = (state_q == S_DONE);
   assign bus_io.sum       = sum_q;
   assign bus_io.cout      = cout_q;
   assign busy_o           = (state_q == S_RUN);
   assign state_o          = state_q;
endmodule
